// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC save-image restore logic.
// Holds the image layout, time constants, FSM state and status encodings,
// and the packed RTC register tuple used by the restorer and the incrementer.
package rtc_pkg;

    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned TIME_W    = 32;
    localparam int unsigned NUM_WORDS = 10;

    localparam logic [DATA_W-1:0] MAGIC = 16'h5254;

    localparam logic [TIME_W-1:0] SECS_PER_DAY  = 32'd86400;
    localparam logic [TIME_W-1:0] SECS_PER_HOUR = 32'd3600;
    localparam logic [TIME_W-1:0] SECS_PER_MIN  = 32'd60;

    // Image word indices
    localparam int unsigned W_TS_LO = 0;
    localparam int unsigned W_TS_HI = 1;
    localparam int unsigned W_SEC   = 2;
    localparam int unsigned W_MIN   = 3;
    localparam int unsigned W_HOUR  = 4;
    localparam int unsigned W_DAY   = 5;
    localparam int unsigned W_FLAGS = 6;
    localparam int unsigned W_MAGIC = 9;

    localparam logic [1:0] STATUS_IDLE      = 2'd0;
    localparam logic [1:0] STATUS_OK        = 2'd1;
    localparam logic [1:0] STATUS_NO_IMAGE  = 2'd2;
    localparam logic [1:0] STATUS_BAD_IMAGE = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_DAYS,
        S_HOURS,
        S_MINS,
        S_SECS,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        U_SEC,
        U_MIN,
        U_HOUR,
        U_DAY
    } rtc_unit_e;

    typedef struct packed {
        logic       carry;
        logic [8:0] day;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } rtc_regs_t;

endpackage

// File: rtl/rtc_incr.sv
// Combinational MBC3 clock increment with cascaded carries.
// Ports:
//   en_i   - perform an increment this cycle
//   unit_i - unit receiving the increment (sec/min/hour/day)
//   regs_i - current {carry, day, hour, min, sec}
//   regs_o - incremented tuple (equals regs_i when en_i is low)
module rtc_incr
    import rtc_pkg::*;
(
    input  logic      en_i,
    input  rtc_unit_e unit_i,
    input  rtc_regs_t regs_i,
    output rtc_regs_t regs_o
);

    logic inc_sec;
    logic inc_min;
    logic inc_hour;
    logic inc_day;

    // 6/5-bit fields wrap from their all-ones value without carrying,
    // matching what the real chip does with out-of-range values.
    always_comb begin
        regs_o   = regs_i;
        inc_sec  = en_i && (unit_i == U_SEC);
        inc_min  = en_i && (unit_i == U_MIN);
        inc_hour = en_i && (unit_i == U_HOUR);
        inc_day  = en_i && (unit_i == U_DAY);

        if (inc_sec) begin
            if (regs_i.sec == 6'd59) begin
                regs_o.sec = 6'd0;
                inc_min    = 1'b1;
            end else if (regs_i.sec == 6'd63) begin
                regs_o.sec = 6'd0;
            end else begin
                regs_o.sec = regs_i.sec + 6'd1;
            end
        end

        if (inc_min) begin
            if (regs_i.min == 6'd59) begin
                regs_o.min = 6'd0;
                inc_hour   = 1'b1;
            end else if (regs_i.min == 6'd63) begin
                regs_o.min = 6'd0;
            end else begin
                regs_o.min = regs_i.min + 6'd1;
            end
        end

        if (inc_hour) begin
            if (regs_i.hour == 5'd23) begin
                regs_o.hour = 5'd0;
                inc_day     = 1'b1;
            end else if (regs_i.hour == 5'd31) begin
                regs_o.hour = 5'd0;
            end else begin
                regs_o.hour = regs_i.hour + 5'd1;
            end
        end

        if (inc_day) begin
            if (regs_i.day == 9'd511) begin
                regs_o.day   = 9'd0;
                regs_o.carry = 1'b1;
            end else begin
                regs_o.day = regs_i.day + 9'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_restore.sv
// Captures the RTC save image from the loader stream, validates it, advances
// the saved clock by the wall-clock time elapsed since the save and presets
// the cartridge RTC with a single rtc_load strobe.
// Ports:
//   clk_sys, reset           - system clock, synchronous active-high reset
//   wr_in, addr_in, data_in  - loader word write stream
//   loading_done             - loader finished level; rising edge starts restore
//   unix_time                - current wall-clock seconds
//   rtc_sec..rtc_carry       - restored clock registers
//   rtc_load                 - one-cycle preset strobe
//   busy                     - restore in progress
//   status                   - 0 idle, 1 ok, 2 no image, 3 bad image
module rtc_restore
    import rtc_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              wr_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              loading_done,
    input  logic [TIME_W-1:0] unix_time,
    output logic [5:0]        rtc_sec,
    output logic [5:0]        rtc_min,
    output logic [4:0]        rtc_hour,
    output logic [8:0]        rtc_day,
    output logic              rtc_halt,
    output logic              rtc_carry,
    output logic              rtc_load,
    output logic              busy,
    output logic [1:0]        status
);

    state_e state_q, state_d;

    logic                 done_q;
    logic [NUM_WORDS-1:0] mask_q, mask_d;
    logic [TIME_W-1:0]    ts_q, ts_d;
    rtc_regs_t            img_q, img_d;
    logic                 img_halt_q, img_halt_d;
    logic [DATA_W-1:0]    magic_q, magic_d;
    rtc_regs_t            work_q, work_d;
    logic                 halt_q, halt_d;
    logic [TIME_W-1:0]    elapsed_q, elapsed_d;
    logic                 busy_q, busy_d;
    logic                 load_q, load_d;
    logic [1:0]           status_q, status_d;

    logic      start;
    logic      fall;
    logic      img_empty;
    logic      img_bad;
    logic      ge_day;
    logic      ge_hour;
    logic      ge_min;
    logic      incr_en;
    rtc_unit_e incr_unit;
    rtc_regs_t incr_regs;

    assign start     = loading_done && !done_q;
    assign fall      = !loading_done && done_q;
    assign img_empty = (mask_q == '0);
    assign img_bad   = (mask_q != '1) || (magic_q != MAGIC);
    assign ge_day    = (elapsed_q >= SECS_PER_DAY);
    assign ge_hour   = (elapsed_q >= SECS_PER_HOUR);
    assign ge_min    = (elapsed_q >= SECS_PER_MIN);

    rtc_incr u_incr (
        .en_i   (incr_en),
        .unit_i (incr_unit),
        .regs_i (work_q),
        .regs_o (incr_regs)
    );

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (img_empty || img_bad) state_d = S_ERROR;
                else                      state_d = S_DAYS;
            end
            S_DAYS: begin
                if (!ge_day) state_d = S_HOURS;
            end
            S_HOURS: begin
                if (!ge_hour) state_d = S_MINS;
            end
            S_MINS: begin
                if (!ge_min) state_d = S_SECS;
            end
            S_SECS: begin
                if (elapsed_q == '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (fall) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        mask_d     = mask_q;
        ts_d       = ts_q;
        img_d      = img_q;
        img_halt_d = img_halt_q;
        magic_d    = magic_q;
        work_d     = work_q;
        halt_d     = halt_q;
        elapsed_d  = elapsed_q;
        status_d   = status_q;
        incr_en    = 1'b0;
        incr_unit  = U_SEC;

        case (state_q)
            S_IDLE: begin
                if (wr_in && (addr_in < ADDR_W'(NUM_WORDS))) begin
                    mask_d[addr_in[3:0]] = 1'b1;
                    case (addr_in[3:0])
                        4'(W_TS_LO): ts_d[15:0]  = data_in;
                        4'(W_TS_HI): ts_d[31:16] = data_in;
                        4'(W_SEC):   img_d.sec   = data_in[5:0];
                        4'(W_MIN):   img_d.min   = data_in[5:0];
                        4'(W_HOUR):  img_d.hour  = data_in[4:0];
                        4'(W_DAY):   img_d.day   = data_in[8:0];
                        4'(W_FLAGS): begin
                            img_halt_d  = data_in[0];
                            img_d.carry = data_in[1];
                        end
                        4'(W_MAGIC): magic_d = data_in;
                        default: ;
                    endcase
                end
            end
            S_CHECK: begin
                if (img_empty) begin
                    status_d = STATUS_NO_IMAGE;
                end else if (img_bad) begin
                    status_d = STATUS_BAD_IMAGE;
                end else begin
                    work_d = img_q;
                    halt_d = img_halt_q;
                    // A halted clock does not advance; a clock behind the save does not run backwards
                    if (img_halt_q || (unix_time < ts_q)) elapsed_d = '0;
                    else                                  elapsed_d = unix_time - ts_q;
                end
            end
            S_DAYS: begin
                if (ge_day) begin
                    elapsed_d = elapsed_q - SECS_PER_DAY;
                    incr_en   = 1'b1;
                    incr_unit = U_DAY;
                    work_d    = incr_regs;
                end
            end
            S_HOURS: begin
                if (ge_hour) begin
                    elapsed_d = elapsed_q - SECS_PER_HOUR;
                    incr_en   = 1'b1;
                    incr_unit = U_HOUR;
                    work_d    = incr_regs;
                end
            end
            S_MINS: begin
                if (ge_min) begin
                    elapsed_d = elapsed_q - SECS_PER_MIN;
                    incr_en   = 1'b1;
                    incr_unit = U_MIN;
                    work_d    = incr_regs;
                end
            end
            S_SECS: begin
                if (elapsed_q != '0) begin
                    elapsed_d = elapsed_q - 32'd1;
                    incr_en   = 1'b1;
                    incr_unit = U_SEC;
                    work_d    = incr_regs;
                end
            end
            S_LOAD: begin
                status_d = STATUS_OK;
            end
            S_DONE, S_ERROR: begin
                if (fall) mask_d = '0;
            end
            default: ;
        endcase

        busy_d = (state_d == S_CHECK) || (state_d == S_DAYS) || (state_d == S_HOURS) ||
                 (state_d == S_MINS)  || (state_d == S_SECS) || (state_d == S_LOAD);
        load_d = (state_d == S_LOAD);
    end

    // Datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Track the level so a loading_done held through reset is not seen as a new edge
            done_q     <= loading_done;
            mask_q     <= '0;
            ts_q       <= '0;
            img_q      <= '0;
            img_halt_q <= 1'b0;
            magic_q    <= '0;
            work_q     <= '0;
            halt_q     <= 1'b0;
            elapsed_q  <= '0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            status_q   <= STATUS_IDLE;
        end else begin
            done_q     <= loading_done;
            mask_q     <= mask_d;
            ts_q       <= ts_d;
            img_q      <= img_d;
            img_halt_q <= img_halt_d;
            magic_q    <= magic_d;
            work_q     <= work_d;
            halt_q     <= halt_d;
            elapsed_q  <= elapsed_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            status_q   <= status_d;
        end
    end

    assign rtc_sec   = work_q.sec;
    assign rtc_min   = work_q.min;
    assign rtc_hour  = work_q.hour;
    assign rtc_day   = work_q.day;
    assign rtc_carry = work_q.carry;
    assign rtc_halt  = halt_q;
    assign rtc_load  = load_q;
    assign busy      = busy_q;
    assign status    = status_q;

endmodule

// File: tb/tb_rtc_restore.sv
// Directed self-checking bench for rtc_restore.
module tb_rtc_restore;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        wr_in;
    logic [16:0] addr_in;
    logic [15:0] data_in;
    logic        loading_done;
    logic [31:0] unix_time;
    logic [5:0]  rtc_sec;
    logic [5:0]  rtc_min;
    logic [4:0]  rtc_hour;
    logic [8:0]  rtc_day;
    logic        rtc_halt;
    logic        rtc_carry;
    logic        rtc_load;
    logic        busy;
    logic [1:0]  status;

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;
    int load_base;

    rtc_restore dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr_in        (wr_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .loading_done (loading_done),
        .unix_time    (unix_time),
        .rtc_sec      (rtc_sec),
        .rtc_min      (rtc_min),
        .rtc_hour     (rtc_hour),
        .rtc_day      (rtc_day),
        .rtc_halt     (rtc_halt),
        .rtc_carry    (rtc_carry),
        .rtc_load     (rtc_load),
        .busy         (busy),
        .status       (status)
    );

    always #5 clk_sys = ~clk_sys;

    // Count cycles during which the load strobe is high
    always @(negedge clk_sys) if (rtc_load) load_cnt = load_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [16:0] a, input logic [15:0] d);
        wr_in   = 1'b1;
        addr_in = a;
        data_in = d;
        @(negedge clk_sys);
        wr_in   = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic load_image(input logic [9:0] which, input logic [31:0] ts,
                              input logic [5:0] s, input logic [5:0] m,
                              input logic [4:0] h, input logic [8:0] d,
                              input logic halt, input logic carry,
                              input logic [15:0] magic);
        logic [15:0] w [10];
        w[0] = ts[15:0];
        w[1] = ts[31:16];
        w[2] = {10'd0, s};
        w[3] = {10'd0, m};
        w[4] = {11'd0, h};
        w[5] = {7'd0, d};
        w[6] = {14'd0, carry, halt};
        w[7] = 16'hdead;
        w[8] = 16'hbeef;
        w[9] = magic;
        for (int i = 0; i < 10; i++) begin
            if (which[i]) write_word(17'(i), w[i]);
        end
    endtask

    // Raise loading_done and wait (bounded) for the restore to finish
    task automatic run_restore(input string tag);
        load_base    = load_cnt;
        loading_done = 1'b1;
        @(negedge clk_sys);
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        for (int n = 0; n < 60000 && busy; n++) @(negedge clk_sys);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    task automatic end_restore();
        loading_done = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic chk_regs(input string tag, input logic [5:0] s, input logic [5:0] m,
                            input logic [4:0] h, input logic [8:0] d,
                            input logic halt, input logic carry);
        chk({tag, "_sec"},   32'(rtc_sec),   32'(s));
        chk({tag, "_min"},   32'(rtc_min),   32'(m));
        chk({tag, "_hour"},  32'(rtc_hour),  32'(h));
        chk({tag, "_day"},   32'(rtc_day),   32'(d));
        chk({tag, "_halt"},  32'(rtc_halt),  32'(halt));
        chk({tag, "_carry"}, 32'(rtc_carry), 32'(carry));
    endtask

    initial begin
        reset        = 1'b1;
        wr_in        = 1'b0;
        addr_in      = '0;
        data_in      = '0;
        loading_done = 1'b0;
        unix_time    = '0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk_regs("rst", 6'd0, 6'd0, 5'd0, 9'd0, 1'b0, 1'b0);
        chk("rst_load", 32'(rtc_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // elapsed 90061 = 1 day + 1 h + 1 min + 1 s; early w2 write is overwritten,
        // out-of-range address is dropped
        write_word(17'd2, 16'd7);
        write_word(17'd12, 16'h1234);
        unix_time = 32'd91061;
        load_image(10'h3FF, 32'd1000, 6'd0, 6'd0, 5'd0, 9'd0, 1'b0, 1'b0, 16'h5254);
        run_restore("full");
        chk_regs("full", 6'd1, 6'd1, 5'd1, 9'd1, 1'b0, 1'b0);
        chk("full_loads", 32'(load_cnt - load_base), 32'd1);
        chk("full_status", 32'(status), 32'd1);
        end_restore();
        chk("full_idle_status", 32'(status), 32'd1);

        // Halted clock keeps its saved values
        load_image(10'h3FF, 32'd1000, 6'd5, 6'd6, 5'd7, 9'd8, 1'b1, 1'b1, 16'h5254);
        run_restore("halt");
        chk_regs("halt", 6'd5, 6'd6, 5'd7, 9'd8, 1'b1, 1'b1);
        chk("halt_loads", 32'(load_cnt - load_base), 32'd1);
        chk("halt_status", 32'(status), 32'd1);
        end_restore();

        // Full cascade: 23:59:59 day 511 + 1 s -> all zero with day carry
        unix_time = 32'd1001;
        load_image(10'h3FF, 32'd1000, 6'd59, 6'd59, 5'd23, 9'd511, 1'b0, 1'b0, 16'h5254);
        run_restore("wrap");
        chk_regs("wrap", 6'd0, 6'd0, 5'd0, 9'd0, 1'b0, 1'b1);
        chk("wrap_loads", 32'(load_cnt - load_base), 32'd1);
        end_restore();

        // Out-of-range seconds wrap without a minute carry
        load_image(10'h3FF, 32'd1000, 6'd63, 6'd10, 5'd3, 9'd4, 1'b0, 1'b0, 16'h5254);
        run_restore("s63");
        chk_regs("s63", 6'd0, 6'd10, 5'd3, 9'd4, 1'b0, 1'b0);
        end_restore();

        // No image at all
        run_restore("empty");
        chk("empty_status", 32'(status), 32'd2);
        chk("empty_loads", 32'(load_cnt - load_base), 32'd0);
        end_restore();

        // Word 4 missing
        load_image(10'h3EF, 32'd1000, 6'd1, 6'd2, 5'd3, 9'd4, 1'b0, 1'b0, 16'h5254);
        run_restore("miss4");
        chk("miss4_status", 32'(status), 32'd3);
        chk("miss4_loads", 32'(load_cnt - load_base), 32'd0);
        end_restore();

        // Wrong magic
        load_image(10'h3FF, 32'd1000, 6'd1, 6'd2, 5'd3, 9'd4, 1'b0, 1'b0, 16'h0000);
        run_restore("magic");
        chk("magic_status", 32'(status), 32'd3);
        chk("magic_loads", 32'(load_cnt - load_base), 32'd0);
        end_restore();

        // Wall clock behind the save timestamp
        unix_time = 32'd100;
        load_image(10'h3FF, 32'd5000, 6'd12, 6'd34, 5'd5, 9'd300, 1'b0, 1'b0, 16'h5254);
        run_restore("behind");
        chk_regs("behind", 6'd12, 6'd34, 5'd5, 9'd300, 1'b0, 1'b0);
        chk("behind_status", 32'(status), 32'd1);
        end_restore();

        // Reset in the middle of the day loop, loading_done held high
        unix_time = 32'd1000000;
        load_image(10'h3FF, 32'd0, 6'd0, 6'd0, 5'd0, 9'd0, 1'b0, 1'b0, 16'h5254);
        load_base    = load_cnt;
        loading_done = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_day_mid", 32'(rtc_day), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk_regs("abort", 6'd0, 6'd0, 5'd0, 9'd0, 1'b0, 1'b0);
        chk("abort_status", 32'(status), 32'd0);
        chk("abort_busy_lo", 32'(busy), 32'd0);
        for (int n = 0; n < 20; n++) @(negedge clk_sys);
        chk("abort_no_restart", 32'(busy), 32'd0);
        chk("abort_loads", 32'(load_cnt - load_base), 32'd0);
        loading_done = 1'b0;
        @(negedge clk_sys);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
